// File: rtl/ds_pkg.sv
// Shared helpers and step encodings for the phase step decoder.
package ds_pkg;

  // Widest phase code the helper functions accept; callers zero-extend to this.
  localparam int unsigned MAX_PHASE = 32;
  localparam int unsigned MAX_IDX_W = $clog2(MAX_PHASE);

  // Classification of one accepted phase change.
  localparam logic [1:0] STEP_NONE  = 2'd0;
  localparam logic [1:0] STEP_LEFT  = 2'd1;
  localparam logic [1:0] STEP_RIGHT = 2'd2;
  localparam logic [1:0] STEP_ERR   = 2'd3;

  // True when exactly one bit of vec is set.
  function automatic logic is_onehot(input logic [MAX_PHASE-1:0] vec);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < MAX_PHASE; i++) begin
      ones = ones + 32'(vec[i]);
    end
    return (ones == 32'd1);
  endfunction

  // Index of the set bit of a one-hot vector (highest set bit otherwise).
  function automatic logic [MAX_IDX_W-1:0] onehot_idx(input logic [MAX_PHASE-1:0] vec);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PHASE; i++) begin
      if (vec[i]) idx = MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/phase_step_decoder_if.sv
// Paddle sensor / game-logic side signals of the phase step decoder.
interface phase_step_decoder_if #(
  parameter int unsigned N_PHASE = 3,
  parameter int unsigned POS_W   = 8
);
  logic [N_PHASE-1:0] in_p;
  logic               pos_clr;
  logic               left_op;
  logic               right_op;
  logic               err_op;
  logic [POS_W-1:0]   pos;
  logic               locked;

  modport master (
    output in_p, pos_clr,
    input  left_op, right_op, err_op, pos, locked
  );

  modport slave (
    input  in_p, pos_clr,
    output left_op, right_op, err_op, pos, locked
  );
endinterface

// File: rtl/ds_debounce.sv
// Two-flop synchroniser followed by a saturating stability counter.
module ds_debounce #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] s2_o,
  output logic             stable_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next state: restart counting whenever the synchronised code moves.
  always_comb begin
    s1_d  = d_i;
    s2_d  = s1_q;
    cnt_d = cnt_q;
    if (s2_d != s2_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_W'(DEBOUNCE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      cnt_q <= cnt_d;
    end
  end

  assign s2_o     = s2_q;
  assign stable_o = (cnt_q == CNT_W'(DEBOUNCE));

endmodule

// File: rtl/phase_step_decoder.sv
// N-phase paddle sensor decoder: debounce, classify steps, track position.
module phase_step_decoder
  import ds_pkg::*;
#(
  parameter int unsigned N_PHASE  = 3,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned WRAP     = 1,
  parameter int unsigned POS_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  phase_step_decoder_if.slave  bus
);

  logic [N_PHASE-1:0] s2;
  logic               stable;

  logic [N_PHASE-1:0] acc_q, acc_d;
  logic               locked_q, locked_d;
  logic               left_q, left_d;
  logic               right_q, right_d;
  logic               err_q, err_d;
  logic [POS_W-1:0]   pos_q, pos_d;

  logic               accept_c;
  logic [1:0]         step_c;
  int unsigned        idx_acc_c;
  int unsigned        idx_new_c;

  ds_debounce #(
    .WIDTH    (N_PHASE),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .d_i      (bus.in_p),
    .s2_o     (s2),
    .stable_o (stable)
  );

  // Accept a stable one-hot code that differs from the current one and classify the move.
  always_comb begin
    accept_c  = stable && is_onehot(MAX_PHASE'(s2)) && (s2 != acc_q);
    idx_acc_c = 32'(onehot_idx(MAX_PHASE'(acc_q)));
    idx_new_c = 32'(onehot_idx(MAX_PHASE'(s2)));
    step_c    = STEP_NONE;
    if (accept_c && locked_q) begin
      if ((idx_new_c == idx_acc_c + 32'd1) ||
          ((WRAP != 0) && (idx_acc_c == N_PHASE - 1) && (idx_new_c == 32'd0))) begin
        step_c = STEP_RIGHT;
      end else if ((idx_new_c + 32'd1 == idx_acc_c) ||
                   ((WRAP != 0) && (idx_acc_c == 32'd0) && (idx_new_c == N_PHASE - 1))) begin
        step_c = STEP_LEFT;
      end else begin
        step_c = STEP_ERR;
      end
    end
  end

  // Next state for the accepted code, lock flag, step pulses and position.
  always_comb begin
    acc_d    = acc_q;
    locked_d = locked_q;
    left_d   = 1'b0;
    right_d  = 1'b0;
    err_d    = 1'b0;
    pos_d    = pos_q;

    if (accept_c) begin
      acc_d    = s2;
      locked_d = 1'b1;
    end

    case (step_c)
      STEP_RIGHT: right_d = 1'b1;
      STEP_LEFT:  left_d  = 1'b1;
      STEP_ERR:   err_d   = 1'b1;
      default:    ;
    endcase

    if (right_d && (pos_q != {POS_W{1'b1}})) begin
      pos_d = pos_q + POS_W'(1);
    end else if (left_d && (pos_q != '0)) begin
      pos_d = pos_q - POS_W'(1);
    end

    // Clearing wins over a simultaneous step; the pulse itself still goes out.
    if (bus.pos_clr) begin
      pos_d = '0;
    end
  end

  // Registered state and outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      locked_q <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      err_q    <= 1'b0;
      pos_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      locked_q <= locked_d;
      left_q   <= left_d;
      right_q  <= right_d;
      err_q    <= err_d;
      pos_q    <= pos_d;
    end
  end

  assign bus.left_op  = left_q;
  assign bus.right_op = right_q;
  assign bus.err_op   = err_q;
  assign bus.pos      = pos_q;
  assign bus.locked   = locked_q;

endmodule

// File: tb/tb_phase_step_decoder.sv
// Bench for phase_step_decoder: three configurations against a sample-history model.
module tb_phase_step_decoder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  phase_step_decoder_if #(.N_PHASE(3), .POS_W(8)) if_a ();
  phase_step_decoder_if #(.N_PHASE(5), .POS_W(8)) if_b ();
  phase_step_decoder_if #(.N_PHASE(4), .POS_W(2)) if_c ();

  phase_step_decoder #(.N_PHASE(3), .DEBOUNCE(4), .WRAP(1), .POS_W(8)) u_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));
  phase_step_decoder #(.N_PHASE(5), .DEBOUNCE(3), .WRAP(0), .POS_W(8)) u_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));
  phase_step_decoder #(.N_PHASE(4), .DEBOUNCE(2), .WRAP(1), .POS_W(2)) u_c (
    .clk(clk), .rst(rst), .bus(if_c.slave));

  // Per-instance configuration.
  int nph [3];
  int dbc [3];
  int wrp [3];
  int pmax[3];

  // Stimulus values.
  logic [7:0] drv [3];
  logic       clr [3];

  // Reference model state: raw samples seen by the synchroniser, newest at index 0.
  logic [7:0] hist [3][8];
  logic [7:0] m_acc [3];
  bit         m_lock[3];
  int         m_pos [3];
  bit         e_l [3];
  bit         e_r [3];
  bit         e_e [3];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 8; t++) hist[k][t] = 8'd0;
      m_acc[k] = 8'd0; m_lock[k] = 0; m_pos[k] = 0;
      e_l[k] = 0; e_r[k] = 0; e_e[k] = 0;
    end
  endtask

  // One rising edge of instance k: a code is accepted once the last DEBOUNCE
  // synchronised samples agree; moves are judged by ring distance.
  task automatic model_edge(input int k);
    logic [7:0] c;
    bit st;
    int i, j, d;
    e_l[k] = 0; e_r[k] = 0; e_e[k] = 0;
    c  = hist[k][1];
    st = 1;
    for (int t = 1; t <= dbc[k]; t++) if (hist[k][t] != c) st = 0;
    if (st && ($countones(c) == 1) && (c != m_acc[k])) begin
      if (m_lock[k]) begin
        i = idx_of(m_acc[k]);
        j = idx_of(c);
        d = (j - i + nph[k]) % nph[k];
        if (d == 1 && (wrp[k] != 0 || j > i)) e_r[k] = 1;
        else if (d == nph[k] - 1 && (wrp[k] != 0 || j < i)) e_l[k] = 1;
        else e_e[k] = 1;
      end
      m_acc[k]  = c;
      m_lock[k] = 1;
    end
    if (e_r[k] && m_pos[k] < pmax[k]) m_pos[k]++;
    if (e_l[k] && m_pos[k] > 0) m_pos[k]--;
    if (clr[k]) m_pos[k] = 0;
    for (int t = 7; t > 0; t--) hist[k][t] = hist[k][t-1];
    hist[k][0] = drv[k];
  endtask

  task automatic check_inst(input int k, input string nm, input logic l, input logic r,
                            input logic e, input logic [31:0] p, input logic lk);
    cmp({nm, "_left"},   32'(l),  32'(e_l[k]));
    cmp({nm, "_right"},  32'(r),  32'(e_r[k]));
    cmp({nm, "_err"},    32'(e),  32'(e_e[k]));
    cmp({nm, "_pos"},    p,       32'(m_pos[k]));
    cmp({nm, "_locked"}, 32'(lk), 32'(m_lock[k]));
  endtask

  task automatic check_all();
    check_inst(0, "a", if_a.left_op, if_a.right_op, if_a.err_op, 32'(if_a.pos), if_a.locked);
    check_inst(1, "b", if_b.left_op, if_b.right_op, if_b.err_op, 32'(if_b.pos), if_b.locked);
    check_inst(2, "c", if_c.left_op, if_c.right_op, if_c.err_op, 32'(if_c.pos), if_c.locked);
  endtask

  // Drive at the falling edge, advance the model at the rising edge, check 1 unit later.
  task automatic tick();
    @(negedge clk);
    if_a.in_p = drv[0][2:0]; if_a.pos_clr = clr[0];
    if_b.in_p = drv[1][4:0]; if_b.pos_clr = clr[1];
    if_c.in_p = drv[2][3:0]; if_c.pos_clr = clr[2];
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
    check_all();
  endtask

  task automatic hold(input int k, input logic [7:0] code, input int n);
    drv[k] = code;
    repeat (n) tick();
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear before any edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  initial begin
    int first;
    int rem[3];
    logic [7:0] msk;
    nph  = '{3, 5, 4};
    dbc  = '{4, 3, 2};
    wrp  = '{1, 0, 1};
    pmax = '{255, 255, 3};
    for (int k = 0; k < 3; k++) begin drv[k] = 8'd0; clr[k] = 1'b0; rem[k] = 0; end
    if_a.in_p = '0; if_a.pos_clr = 1'b0;
    if_b.in_p = '0; if_b.pos_clr = 1'b0;
    if_c.in_p = '0; if_c.pos_clr = 1'b0;
    model_reset();
    rst = 1'b1;
    #1;
    check_all();
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;

    // Basic stepping on the 3-phase ring: lock, then two right steps.
    hold(0, 8'b001, 10);
    cmp("a_locked_first", 32'(if_a.locked), 32'd1);
    drv[0] = 8'b010;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (if_a.right_op === 1'b1 && first == 0) first = i;
    end
    cmp("a_pulse_latency", 32'(first), 32'd6);
    hold(0, 8'b100, 10);
    cmp("a_pos_two_steps", 32'(if_a.pos), 32'd2);

    // Wrap: 100 -> 001 is right, 001 -> 100 is left.
    hold(0, 8'b001, 10);
    cmp("a_pos_after_wrap_right", 32'(if_a.pos), 32'd3);
    hold(0, 8'b100, 10);
    cmp("a_pos_after_wrap_left", 32'(if_a.pos), 32'd2);

    // Glitch, bounce back and invalid codes produce nothing; acc stays 100.
    hold(0, 8'b001, 3);
    hold(0, 8'b100, 10);
    hold(0, 8'b011, 20);
    hold(0, 8'b000, 20);
    hold(0, 8'b100, 10);
    cmp("a_pos_after_glitch", 32'(if_a.pos), 32'd2);
    hold(0, 8'b010, 10);
    cmp("a_pos_left_from_100", 32'(if_a.pos), 32'd1);

    // Linear strip: skip is an error, then an adjacent move is a right step.
    hold(1, 8'b00001, 10);
    hold(1, 8'b00100, 10);
    cmp("b_pos_after_skip", 32'(if_b.pos), 32'd0);
    hold(1, 8'b01000, 10);
    cmp("b_pos_after_right", 32'(if_b.pos), 32'd1);
    hold(1, 8'b10000, 10);
    hold(1, 8'b00001, 10);
    cmp("b_pos_no_wrap", 32'(if_b.pos), 32'd2);

    // Saturation on a 2-bit counter: five rights give 3.
    hold(2, 8'b0001, 8);
    hold(2, 8'b0010, 8);
    hold(2, 8'b0100, 8);
    hold(2, 8'b1000, 8);
    hold(2, 8'b0001, 8);
    hold(2, 8'b0010, 8);
    cmp("c_pos_saturated", 32'(if_c.pos), 32'd3);
    // Clear in the same cycle as a right pulse.
    drv[2] = 8'b0100;
    repeat (3) tick();
    clr[2] = 1'b1;
    tick();
    cmp("c_right_with_clr", 32'(if_c.right_op), 32'd1);
    cmp("c_pos_clr_wins", 32'(if_c.pos), 32'd0);
    clr[2] = 1'b0;
    repeat (5) tick();
    // Left step at zero stays at zero.
    hold(2, 8'b0010, 8);
    cmp("c_pos_floor", 32'(if_c.pos), 32'd0);

    // Reset two cycles into debouncing a new code; the code then only re-locks.
    hold(0, 8'b100, 2);
    do_reset();
    cmp("a_locked_in_reset", 32'(if_a.locked), 32'd0);
    hold(0, 8'b100, 10);
    cmp("a_relocked", 32'(if_a.locked), 32'd1);
    cmp("a_pos_after_relock", 32'(if_a.pos), 32'd0);

    // Randomised phase for all three instances.
    for (int it = 0; it < 800; it++) begin
      for (int k = 0; k < 3; k++) begin
        if (rem[k] == 0) begin
          msk = 8'((1 << nph[k]) - 1);
          if ($urandom_range(0, 9) < 7) drv[k] = 8'(1 << $urandom_range(0, nph[k] - 1));
          else drv[k] = 8'($urandom) & msk;
          rem[k] = int'($urandom_range(1, dbc[k] + 5));
        end
        rem[k]--;
        clr[k] = ($urandom_range(0, 19) == 0);
      end
      tick();
      if (it == 400) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
